// File: rtl/maze_if.sv
// Bus between the pixel-index generator / game controller and the maze renderer.
// A move transfers on any rising edge where move_valid and move_ready are both high; move_valid
// presented while move_ready is low is dropped rather than held, and completion is move_done.
interface maze_if #(
  parameter int IW = 13,
  parameter int AW = 7
);
  logic [IW-1:0] index;
  logic [15:0]   data;
  logic          map_we;
  logic [AW-1:0] map_addr;
  logic          map_din;
  logic          move_valid;
  logic [1:0]    move_dir;
  logic          move_ready;
  logic          move_done;
  logic          move_ok;
  logic          at_goal;

  modport master (
    output index, map_we, map_addr, map_din, move_valid, move_dir,
    input  data, move_ready, move_done, move_ok, at_goal
  );

  modport slave (
    input  index, map_we, map_addr, map_din, move_valid, move_dir,
    output data, move_ready, move_done, move_ok, at_goal
  );
endinterface

// File: rtl/maze_renderer.sv
// Maze pixel source: writable wall bitmap, player sprite and goal cell rendered to RGB565
// through a 2-stage pipeline; player moves via a small check-then-commit FSM.
module maze_renderer #(
  parameter int          SCR_W        = 96,
  parameter int          SCR_H        = 64,
  parameter int          CELL         = 8,
  parameter int          START_COL    = 0,
  parameter int          START_ROW    = 0,
  parameter int          GOAL_COL     = 11,
  parameter int          GOAL_ROW     = 7,
  parameter logic [15:0] WALL_COLOR   = 16'hFFFF,
  parameter logic [15:0] PATH_COLOR   = 16'h0000,
  parameter logic [15:0] PLAYER_COLOR = 16'h07E0,
  parameter logic [15:0] GOAL_COLOR   = 16'h001F
) (
  input  logic       clk,
  input  logic       rst_n,
  maze_if.slave      bus,
  output logic [1:0] dbg_state_o
);
  localparam int GW    = SCR_W / CELL;
  localparam int GH    = SCR_H / CELL;
  localparam int NCELL = GW * GH;
  localparam int NPIX  = SCR_W * SCR_H;
  localparam int AW    = $clog2(NCELL);
  localparam int CW    = $clog2(SCR_W);
  localparam int RW    = $clog2(SCR_H);
  localparam int GCW   = $clog2(GW);
  localparam int GRW   = $clog2(GH);
  localparam int CSH   = $clog2(CELL);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic             acc_q, acc_d;
  logic [GCW-1:0]   tcol_q, tcol_d, pcol_q, pcol_d;
  logic [GRW-1:0]   trow_q, trow_d, prow_q, prow_d;
  logic [NCELL-1:0] map_q;
  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic             oor_q;
  logic [15:0]      data_q, data_d;
  logic [GCW-1:0]   s2_cc;
  logic [GRW-1:0]   s2_cr;
  logic [AW-1:0]    s2_addr, t_addr;
  logic             off_grid;

  // Map write port; addresses past the grid are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= '0;
    end else if (bus.map_we && (32'(bus.map_addr) < NCELL)) begin
      map_q[bus.map_addr] <= bus.map_din;
    end
  end

  // Stage 1: split the linear index into pixel column/row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      oor_q <= 1'b0;
    end else begin
      col_q <= CW'(32'(bus.index) % SCR_W);
      row_q <= RW'(32'(bus.index) / SCR_W);
      oor_q <= (32'(bus.index) >= NPIX);
    end
  end

  // Stage 2: colour from live player position and map contents.
  assign s2_cc   = GCW'(col_q >> CSH);
  assign s2_cr   = GRW'(row_q >> CSH);
  assign s2_addr = AW'(32'(s2_cr) * GW + 32'(s2_cc));

  always_comb begin
    data_d = PATH_COLOR;
    if (oor_q) begin
      data_d = PATH_COLOR;
    end else if ((s2_cc == pcol_q) && (s2_cr == prow_q)) begin
      data_d = PLAYER_COLOR;
    end else if ((s2_cc == GCW'(GOAL_COL)) && (s2_cr == GRW'(GOAL_ROW))) begin
      data_d = GOAL_COLOR;
    end else if (map_q[s2_addr]) begin
      data_d = WALL_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Move FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 2'd0;
      acc_q   <= 1'b0;
      tcol_q  <= GCW'(START_COL);
      trow_q  <= GRW'(START_ROW);
      pcol_q  <= GCW'(START_COL);
      prow_q  <= GRW'(START_ROW);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      tcol_q  <= tcol_d;
      trow_q  <= trow_d;
      pcol_q  <= pcol_d;
      prow_q  <= prow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    acc_d          = acc_q;
    tcol_d         = tcol_q;
    trow_d         = trow_q;
    pcol_d         = pcol_q;
    prow_d         = prow_q;
    off_grid       = 1'b0;
    t_addr         = '0;
    bus.move_ready = 1'b0;
    bus.move_done  = 1'b0;
    bus.move_ok    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.move_ready = 1'b1;
        if (bus.move_valid) begin
          dir_d   = bus.move_dir;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        tcol_d = pcol_q;
        trow_d = prow_q;
        case (dir_q)
          2'd0: if (prow_q == '0) off_grid = 1'b1; else trow_d = prow_q - 1'b1;
          2'd1: if (prow_q == GRW'(GH - 1)) off_grid = 1'b1; else trow_d = prow_q + 1'b1;
          2'd2: if (pcol_q == '0) off_grid = 1'b1; else tcol_d = pcol_q - 1'b1;
          default: if (pcol_q == GCW'(GW - 1)) off_grid = 1'b1; else tcol_d = pcol_q + 1'b1;
        endcase
        t_addr  = AW'(32'(trow_d) * GW + 32'(tcol_d));
        acc_d   = !off_grid && !map_q[t_addr];
        state_d = S_DONE;
      end
      S_DONE: begin
        bus.move_done = 1'b1;
        bus.move_ok   = acc_q;
        if (acc_q) begin
          pcol_d = tcol_q;
          prow_d = trow_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data     = data_q;
  assign bus.at_goal  = (pcol_q == GCW'(GOAL_COL)) && (prow_q == GRW'(GOAL_ROW));
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_maze_renderer.sv
// Bench for maze_renderer: cell-level maze/player model, randomized moves, map writes and pixels.
module tb_maze_renderer;
  localparam logic [15:0] WALL   = 16'hFFFF;
  localparam logic [15:0] PATH   = 16'h0000;
  localparam logic [15:0] PLAYER = 16'h07E0;
  localparam logic [15:0] GOAL   = 16'h001F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  maze_if bus ();

  maze_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Reference model: wall bitmap indexed row*12+col, player cell.
  bit map_m[96];
  int pc = 0;
  int pr = 0;
  logic [12:0] idx_q[$];

  function automatic logic [15:0] model_pix(int idx);
    int c, r;
    if (idx >= 96 * 64) return PATH;
    c = (idx % 96) / 8;
    r = (idx / 96) / 8;
    if (c == pc && r == pr) return PLAYER;
    if (c == 11 && r == 7) return GOAL;
    if (map_m[r * 12 + c]) return WALL;
    return PATH;
  endfunction

  function automatic bit model_move(input int dir, output int tc, output int tr);
    tc = pc;
    tr = pr;
    case (dir)
      0: tr = pr - 1;
      1: tr = pr + 1;
      2: tc = pc - 1;
      default: tc = pc + 1;
    endcase
    if (tc < 0 || tc > 11 || tr < 0 || tr > 7) return 1'b0;
    return !map_m[tr * 12 + tc];
  endfunction

  task automatic model_reset();
    pc = 0;
    pr = 0;
    for (int i = 0; i < 96; i++) map_m[i] = 1'b0;
  endtask

  task automatic check_pixel(input int idx, input string name);
    logic [15:0] exp;
    bus.index = 13'(idx);
    @(posedge clk);
    @(posedge clk);
    #1;
    exp = model_pix(idx);
    tests_run++;
    if (bus.data !== exp) begin
      fails++;
      $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, bus.data, exp);
    end
  endtask

  task automatic write_map(input int addr, input bit din);
    bus.map_we   = 1'b1;
    bus.map_addr = 7'(addr);
    bus.map_din  = din;
    @(posedge clk);
    #1;
    bus.map_we = 1'b0;
    if (addr < 96) map_m[addr] = din;
  endtask

  task automatic do_move(input int dir, input bit hold);
    int  tc, tr;
    bit  ok;
    ok = model_move(dir, tc, tr);
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'(dir);
    @(posedge clk);
    #1;
    if (!hold) bus.move_valid = 1'b0;
    tests_run++;
    if (bus.move_ready !== 1'b0 || bus.move_done !== 1'b0) begin
      fails++;
      $display("FAIL move_check_phase ready=%b done=%b exp ready=0 done=0", bus.move_ready, bus.move_done);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.move_done !== 1'b1 || bus.move_ok !== ok) begin
      fails++;
      $display("FAIL move_done dir=%0d at (%0d,%0d) got done=%b ok=%b exp done=1 ok=%b",
               dir, pc, pr, bus.move_done, bus.move_ok, ok);
    end
    @(posedge clk);
    #1;
    bus.move_valid = 1'b0;
    if (ok) begin
      pc = tc;
      pr = tr;
    end
    tests_run++;
    if (bus.move_done !== 1'b0 || bus.move_ready !== 1'b1 || bus.at_goal !== (pc == 11 && pr == 7)) begin
      fails++;
      $display("FAIL move_after got done=%b ready=%b at_goal=%b exp done=0 ready=1 at_goal=%b",
               bus.move_done, bus.move_ready, bus.at_goal, (pc == 11 && pr == 7));
    end
    if (hold) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.move_ready !== 1'b1 || bus.move_done !== 1'b0) begin
        fails++;
        $display("FAIL move_not_queued got ready=%b done=%b exp ready=1 done=0", bus.move_ready, bus.move_done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.index      = '0;
    bus.map_we     = 1'b0;
    bus.map_addr   = '0;
    bus.map_din    = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.data !== 16'h0 || bus.move_ready !== 1'b1 || bus.move_done !== 1'b0 ||
        bus.move_ok !== 1'b0 || bus.at_goal !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs data=%h ready=%b done=%b ok=%b goal=%b exp 0000/1/0/0/0",
               bus.data, bus.move_ready, bus.move_done, bus.move_ok, bus.at_goal);
    end
    rst_n = 1'b1;
    check_pixel(0, "reset_player_px");
    check_pixel(6143, "reset_goal_px");
    check_pixel(6144, "reset_oor_px");
  endtask

  task automatic test_map_pixels();
    write_map(1, 1'b1);
    check_pixel(8, "wall_px");
    check_pixel(7, "player_edge_px");
    write_map(100, 1'b1);
    check_pixel(4 * 96 * 8 + 4 * 8, "ignored_addr_px");
    for (int i = 0; i < 20; i++) check_pixel($urandom_range(0, 8191), "random_px");
  endtask

  task automatic test_moves();
    do_move(2, 1'b0);
    do_move(1, 1'b0);
    check_pixel(8 * 96 + 3, "player_moved_px");
    check_pixel(2, "old_cell_px");
    do_move(0, 1'b0);
    do_move(3, 1'b0);
    write_map(1, 1'b0);
    do_move(3, 1'b0);
    check_pixel(9, "player_right_px");
  endtask

  task automatic test_random_moves();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) write_map($urandom_range(0, 127), ($urandom_range(0, 3) == 0));
      do_move($urandom_range(0, 3), 1'(($urandom_range(0, 3) == 0)));
      if (i % 4 == 0) check_pixel(pr * 768 + pc * 8 + $urandom_range(0, 7) * 96 + $urandom_range(0, 7), "player_cell_px");
      if (i % 3 == 0) check_pixel($urandom_range(0, 8191), "random_walk_px");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) write_map(i * 17 % 96, 1'b0);
    do_move(1, 1'b1);
    do_move(3, 1'b0);
    do_move(0, 1'b0);
    do_move(2, 1'b0);
  endtask

  task automatic test_stream();
    int          m = 3000;
    int          dir = 0;
    int          tc, tr, stc, str;
    int          shown = 0;
    bit          ok = 1'b0;
    logic [12:0] idx;
    logic [15:0] exp;
    for (int d = 3; d >= 0; d--) if (model_move(d, tc, tr)) dir = d;
    @(posedge clk);
    #1;
    for (int j = 0; j < 6146; j++) begin
      if (j >= 2) begin
        idx = idx_q.pop_front();
        exp = model_pix(int'(idx));
        tests_run++;
        if (bus.data !== exp) begin
          fails++;
          if (shown < 10) $display("FAIL stream_px idx=%0d got=%h exp=%h", idx, bus.data, exp);
          shown++;
        end
      end
      if (j == m + 3 && ok) begin
        pc = stc;
        pr = str;
      end
      if (j == m) begin
        ok = model_move(dir, stc, str);
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'(dir);
      end
      if (j == m + 1) bus.move_valid = 1'b0;
      if (j == m + 2) begin
        tests_run++;
        if (bus.move_done !== 1'b1 || bus.move_ok !== ok) begin
          fails++;
          $display("FAIL stream_move got done=%b ok=%b exp done=1 ok=%b", bus.move_done, bus.move_ok, ok);
        end
      end
      if (j < 6144) begin
        bus.index = 13'(j);
        idx_q.push_back(13'(j));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_move();
    write_map(5, 1'b1);
    check_pixel(40, "pre_reset_px");
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd1;
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    bus.move_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.data !== 16'h0 || bus.move_ready !== 1'b1 || bus.move_done !== 1'b0 || bus.at_goal !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort data=%h ready=%b done=%b goal=%b exp 0000/1/0/0",
               bus.data, bus.move_ready, bus.move_done, bus.at_goal);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) rst_n = 1'b1;
      tests_run++;
      if (bus.move_done !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_done cycle=%0d got done=%b exp 0", i, bus.move_done);
      end
    end
    check_pixel(0, "reset_start_px");
    check_pixel(40, "reset_map_cleared_px");
  endtask

  task automatic test_goal();
    for (int i = 0; i < 11; i++) do_move(3, 1'b0);
    for (int i = 0; i < 7; i++) do_move(1, 1'b0);
    tests_run++;
    if (bus.at_goal !== 1'b1) begin
      fails++;
      $display("FAIL at_goal got=%b exp=1", bus.at_goal);
    end
    check_pixel(7 * 768 + 11 * 8, "goal_player_px");
    do_move(3, 1'b0);
    do_move(1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_map_pixels();
    test_moves();
    test_random_moves();
    test_back_to_back();
    test_stream();
    test_reset_mid_move();
    test_goal();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
